// File: rtl/ed_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ed_ctrl_pkg
// Shared types for the energy-detector control unit.
//   state_e : sequencer states, in frame order
//   WS_W    : width of the window_size (samples per frame) field
// -----------------------------------------------------------------------------
package ed_ctrl_pkg;

    localparam int WS_W = 10;

    typedef enum logic [3:0] {
        INIT,
        IDLE,
        LOAD,
        FLUSH,
        THADD,
        SUB,
        DECIDE,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/ed_ctrl_dly.sv
// -----------------------------------------------------------------------------
// ed_ctrl_dly
// LAT-deep 1-bit shift register that re-times a FIFO pop strobe so that it
// lines up with the cycle in which the popped word is valid on the FIFO output.
//   clock : system clock, rising edge
//   rst   : asynchronous, active-high reset
//   din   : pop strobe
//   dout  : pop strobe delayed LAT cycles
//   busy  : at least one pop is still travelling through the line
// -----------------------------------------------------------------------------
module ed_ctrl_dly #(
    parameter int LAT = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic busy
);

    logic [LAT-1:0] sr_q;
    logic [LAT-1:0] sr_d;

    generate
        if (LAT == 1) begin : g_one
            always_comb sr_d = din;
        end else begin : g_multi
            always_comb sr_d = {sr_q[LAT-2:0], din};
        end
    endgenerate

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, regardless of process order.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = sr_q[LAT-1];
    assign busy = |sr_q;

endmodule

// File: rtl/control_unit_ed.sv
// -----------------------------------------------------------------------------
// control_unit_ed
// Frame sequencer for datapath_unit_ed. For each frame it pops window_size
// samples from the input FIFO into the energy / threshold accumulators and the
// output FIFO, adds the threshold, subtracts, latches the detection bit, then
// drains the frame to the output port under out_ready back-pressure.
//
// Ports
//   clock, rst              : clock (rising edge), async active-high reset
//   run                     : level; low stops after the current frame
//   out_ready               : downstream accepts a word FIFO_RD_LAT cycles on
//   empty_fin               : input FIFO empty
//   cnt1_tc / cnt2_tc       : load / drain counter reached window_size
//   window_size [WS_W]      : samples per frame, 0 is illegal
//   pop/push/sclr_fin/fout  : FIFO controls (push_fin, sclr_fin tied 0)
//   sclr/ce/add_subn_ew, ce_thw, select_th : accumulator controls
//   sclr/en_cnt1, sclr/en_cnt2, sclr/en_dres, end_sig : counter/result controls
//   out_valid               : output word valid
//   cfg_err                 : sticky, run seen with window_size == 0
//
// Optional feature (macro ED_CTRL_FRAME_CNT_EN):
//   adds input d_res (latched detection bit from the datapath) and output
//   frame_cnt [FCNT_W-1:0], counting frames that ended with a detection.
// -----------------------------------------------------------------------------
import ed_ctrl_pkg::*;

module control_unit_ed #(
    parameter int FIFO_RD_LAT = 1
`ifdef ED_CTRL_FRAME_CNT_EN
    ,
    parameter int FCNT_W = 16
`endif
) (
    input  logic            clock,
    input  logic            rst,
    input  logic            run,
    input  logic            out_ready,
    input  logic            empty_fin,
    input  logic            cnt1_tc,
    input  logic            cnt2_tc,
    input  logic [WS_W-1:0] window_size,
`ifdef ED_CTRL_FRAME_CNT_EN
    input  logic            d_res,
`endif
    output logic            pop_fin,
    output logic            push_fin,
    output logic            sclr_fin,
    output logic            pop_fout,
    output logic            push_fout,
    output logic            sclr_fout,
    output logic            sclr_ew,
    output logic            ce_ew,
    output logic            add_subn_ew,
    output logic            ce_thw,
    output logic            select_th,
    output logic            sclr_cnt1,
    output logic            en_cnt1,
    output logic            sclr_cnt2,
    output logic            en_cnt2,
    output logic            sclr_dres,
    output logic            en_dres,
    output logic            end_sig,
    output logic            out_valid,
    output logic            cfg_err
`ifdef ED_CTRL_FRAME_CNT_EN
    ,
    output logic [FCNT_W-1:0] frame_cnt
`endif
);

    state_e state_q, state_d;
    logic   armed_q, armed_d;
    logic   cfg_err_q, cfg_err_d;
    logic   fin_dly, fin_busy;
    logic   fout_dly, fout_busy;

    // Ingest logic owns the FIN write; pending input survives every clear.
    assign push_fin = 1'b0;
    assign sclr_fin = 1'b0;

    // Pop strobes re-timed to the cycle the FIFO data is valid.
    ed_ctrl_dly #(.LAT(FIFO_RD_LAT)) u_dly_fin (
        .clock (clock),
        .rst   (rst),
        .din   (pop_fin),
        .dout  (fin_dly),
        .busy  (fin_busy)
    );

    ed_ctrl_dly #(.LAT(FIFO_RD_LAT)) u_dly_fout (
        .clock (clock),
        .rst   (rst),
        .din   (pop_fout),
        .dout  (fout_dly),
        .busy  (fout_busy)
    );

    // armed_q holds off the INIT clear pulse until the cycle after reset
    // release, so every output stays low while rst is high.
    always_comb begin
        armed_d   = 1'b1;
        cfg_err_d = cfg_err_q | ((state_q == IDLE) && run && (window_size == '0));
    end

    // ---------------- state register ----------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            armed_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:   if (armed_q) state_d = IDLE;
            IDLE:   if (run && (window_size != '0) && !empty_fin) state_d = LOAD;
            LOAD:   if (cnt1_tc) state_d = FLUSH;
            FLUSH:  if (!fin_busy) state_d = THADD;
            THADD:  state_d = SUB;
            SUB:    state_d = DECIDE;
            DECIDE: state_d = DRAIN;
            // Leave only once the last popped word has been presented.
            DRAIN:  if (cnt2_tc && !fout_busy) state_d = DONE;
            DONE:   state_d = (run && !empty_fin) ? LOAD : IDLE;
            default: state_d = INIT;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would infer a latch.
        pop_fin     = 1'b0;
        pop_fout    = 1'b0;
        sclr_fout   = 1'b0;
        sclr_ew     = 1'b0;
        add_subn_ew = 1'b0;
        select_th   = 1'b0;
        sclr_cnt1   = 1'b0;
        en_cnt1     = 1'b0;
        sclr_cnt2   = 1'b0;
        en_cnt2     = 1'b0;
        sclr_dres   = 1'b0;
        en_dres     = 1'b0;
        end_sig     = 1'b0;
        // Data-valid strobes follow the pops regardless of state, so words
        // still in flight when LOAD/DRAIN ends are not lost.
        ce_ew       = fin_dly;
        ce_thw      = fin_dly;
        push_fout   = fin_dly;
        out_valid   = fout_dly;

        case (state_q)
            INIT: begin
                if (armed_q) begin
                    sclr_fout = 1'b1;
                    sclr_ew   = 1'b1;
                    sclr_cnt1 = 1'b1;
                    sclr_cnt2 = 1'b1;
                    sclr_dres = 1'b1;
                end
            end
            LOAD: begin
                // Gating with !empty_fin makes an empty FIFO a plain stall.
                pop_fin     = !empty_fin && !cnt1_tc;
                en_cnt1     = pop_fin;
                add_subn_ew = 1'b1;
            end
            FLUSH: begin
                add_subn_ew = 1'b1;
            end
            THADD: begin
                select_th = 1'b1;
                ce_thw    = 1'b1;
            end
            SUB: begin
                ce_ew = 1'b1;
            end
            DECIDE: begin
                en_dres = 1'b1;
            end
            DRAIN: begin
                pop_fout = out_ready && !cnt2_tc;
                en_cnt2  = pop_fout;
            end
            DONE: begin
                end_sig   = 1'b1;
                sclr_ew   = 1'b1;
                sclr_cnt1 = 1'b1;
                sclr_cnt2 = 1'b1;
            end
            default: ;
        endcase
    end

    assign cfg_err = cfg_err_q;

`ifdef ED_CTRL_FRAME_CNT_EN
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // d_res was latched in DECIDE, so it is this frame's result during DONE.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if ((state_q == DONE) && d_res) frame_cnt_d = frame_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) frame_cnt_q <= '0;
        else     frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
